// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines and a single outstanding refill.
// Line storage is present only when ICACHE_EN is defined; otherwise every fetch is served by memory.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        in_clear,
  input  logic        in_fetcher_ena,
  input  logic [31:0] in_fetcher_addr,
  output logic        out_fetcher_ok,
  output logic [31:0] out_fetcher_inst,
  output logic        out_mem_ena,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ok,
  input  logic [31:0] in_mem_data
);

  typedef enum logic {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_ok;
  logic        w_ok_next;
  logic [31:0] r_inst;
  logic [31:0] w_inst_next;
  logic        r_mem_ena;
  logic        w_mem_ena_next;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_next;
  logic        w_fill;
  logic        w_hit;
  logic [31:0] w_hit_data;
  logic        w_unused;

`ifdef ICACHE_EN
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 16 - INDEX_BITS;

  logic [31:0]           r_data [LINES];
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [LINES-1:0]      r_valid;
  logic [INDEX_BITS-1:0] w_rd_index;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [INDEX_BITS-1:0] w_wr_index;
  logic [TAG_BITS-1:0]   w_wr_tag;

  assign w_rd_index = in_fetcher_addr[INDEX_BITS+1:2];
  assign w_rd_tag   = in_fetcher_addr[17:INDEX_BITS+2];
  // The refill line is addressed from the latched miss address, not the live fetch address.
  assign w_wr_index = r_mem_addr[INDEX_BITS+1:2];
  assign w_wr_tag   = r_mem_addr[17:INDEX_BITS+2];
  assign w_hit      = r_valid[w_rd_index] && (r_tag[w_rd_index] == w_rd_tag);
  assign w_hit_data = r_data[w_rd_index];
  assign w_unused   = &{1'b0, in_fetcher_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (ena && w_fill) begin
      r_valid[w_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ena && w_fill) begin
      r_data[w_wr_index] <= in_mem_data;
      r_tag[w_wr_index]  <= w_wr_tag;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
  assign w_unused   = &{1'b0, in_fetcher_addr[1:0], w_fill};
`endif

  // Clear overrides everything, including a refill arriving in the same cycle.
  always_comb begin
    w_state_next    = r_state;
    w_ok_next       = 1'b0;
    w_inst_next     = r_inst;
    w_mem_ena_next  = r_mem_ena;
    w_mem_addr_next = r_mem_addr;
    w_fill          = 1'b0;
    if (in_clear) begin
      w_state_next   = IDLE;
      w_mem_ena_next = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_fetcher_ena && !r_ok) begin
            if (w_hit) begin
              w_ok_next   = 1'b1;
              w_inst_next = w_hit_data;
            end else begin
              w_state_next    = MISS_WAIT;
              w_mem_ena_next  = 1'b1;
              w_mem_addr_next = {in_fetcher_addr[31:2], 2'b00};
            end
          end
        end
        MISS_WAIT: begin
          if (in_mem_ok) begin
            w_fill         = 1'b1;
            w_state_next   = IDLE;
            w_mem_ena_next = 1'b0;
            w_ok_next      = 1'b1;
            w_inst_next    = in_mem_data;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ok       <= 1'b0;
      r_inst     <= '0;
      r_mem_ena  <= 1'b0;
      r_mem_addr <= '0;
    end else if (ena) begin
      r_state    <= w_state_next;
      r_ok       <= w_ok_next;
      r_inst     <= w_inst_next;
      r_mem_ena  <= w_mem_ena_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  assign out_fetcher_ok   = r_ok;
  assign out_fetcher_inst = r_inst;
  assign out_mem_ena      = r_mem_ena;
  assign out_mem_addr     = r_mem_addr;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have parameter INDEX_BITS, default 6, number of index bits (2^INDEX_BITS one-word lines).
REQ-002 The module SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port ena, input, 1, global ready; low freezes all state.
REQ-005 The module SHALL have port in_clear, input, 1, misbranch flush; abandons the outstanding request.
REQ-006 The module SHALL have port in_fetcher_ena, input, 1, fetch request; held high with a stable address until out_fetcher_ok.
REQ-007 The module SHALL have port in_fetcher_addr, input, 32, instruction address; bits [1:0] ignored.
REQ-008 The module SHALL have port out_fetcher_ok, output, 1, one-cycle pulse marking out_fetcher_inst valid.
REQ-009 The module SHALL have port out_fetcher_inst, output, 32, returned instruction word.
REQ-010 The module SHALL have port out_mem_ena, output, 1, refill request to the memory unit.
REQ-011 The module SHALL have port out_mem_addr, output, 32, word-aligned refill address.
REQ-012 The module SHALL have port in_mem_ok, input, 1, refill data valid, one cycle.
REQ-013 The module SHALL have port in_mem_data, input, 32, refill word.

Function
REQ-014 The cache SHALL be direct-mapped: index = addr[INDEX_BITS+1:2], tag = addr[17:INDEX_BITS+2], plus one valid bit per line.
REQ-015 The FSM SHALL have two states: IDLE and MISS_WAIT.
REQ-016 A request SHALL be accepted in IDLE when in_fetcher_ena=1, out_fetcher_ok=0 and ena=1.
REQ-017 On a hit, the cache SHALL pulse out_fetcher_ok with the line data on the next cycle, stay in IDLE and issue no memory request.
REQ-018 On a miss, the cache SHALL enter MISS_WAIT and drive out_mem_ena=1 with out_mem_addr={addr[31:2],2'b00} from the next cycle until in_mem_ok.
REQ-019 On in_mem_ok in MISS_WAIT, the cache SHALL write data, tag and valid into the line, deassert out_mem_ena, return to IDLE, and pulse out_fetcher_ok with in_mem_data on the next cycle.
REQ-020 in_clear=1 SHALL force IDLE, drop out_mem_ena and suppress any pending out_fetcher_ok on the next cycle; valid bits are retained.
REQ-021 When in_clear and in_mem_ok coincide, clear SHALL win: no line write, no ok pulse.
REQ-022 Requests arriving in MISS_WAIT SHALL be ignored; the fetcher keeps holding them.
REQ-023 With ena=0, FSM, outputs, lines and valid bits SHALL hold their values, and in_mem_ok SHALL be ignored.
REQ-024 The memory unit SHALL be reset by the same clear, so no stale in_mem_ok arrives after a clear.

Reset
REQ-025 rst SHALL asynchronously clear all valid bits, set state IDLE, and set out_fetcher_ok=0, out_fetcher_inst=0, out_mem_ena=0, out_mem_addr=0.
REQ-026 rst asserted mid-miss SHALL abandon the refill; the first post-reset request SHALL miss.

Configuration
REQ-027 Macro ICACHE_EN SHALL gate the storage: when defined, REQ-014..REQ-019 apply.
REQ-028 Without ICACHE_EN, every accepted request SHALL take the miss path with no line storage, and clear/ena/reset rules are unchanged.

Verification
REQ-029 The bench SHALL check the cold miss: fetch 0x0; in_mem_ok with 0x00000413 two cycles later -> out_mem_ena high with addr 0x0 until ok, then out_fetcher_ok=1 with inst 0x00000413 on the next cycle.
REQ-030 The bench SHALL check the re-fetch hit: fetch 0x0 again -> ok on the next cycle with 0x00000413 and out_mem_ena stays 0.
REQ-031 The bench SHALL check a conflict miss (INDEX_BITS=6): fetch 0x100 -> miss (index 0, tag differs); fill 0x00A00093; a subsequent fetch of 0x0 misses again.
REQ-032 The bench SHALL check clear during a miss: fetch 0x8, in_clear in MISS_WAIT -> out_mem_ena 0 on the next cycle and no ok; fetch 0x8 again -> new miss.
REQ-033 The bench SHALL check coincident clear and refill: in_clear and in_mem_ok in the same cycle -> no ok pulse, and a later fetch of the same address misses.
REQ-034 The bench SHALL check the ena freeze: ena=0 for 3 cycles mid-miss with in_mem_ok pulsed -> state held and ok ignored; refill completes after ena returns and in_mem_ok is reasserted.
